// File: rtl/id_ex_pipe_buf_if.sv
// ============================================================================
// Module      : id_ex_pipe_buf_if
// Description : Decode-to-execute bus: upstream handshake + fields, downstream
//               handshake + fields, flush and stall counter.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface id_ex_pipe_buf_if #(
    parameter int WB_SIZE  = 4,
    parameter int MEM_SIZE = 6,
    parameter int EX_SIZE  = 3,
    parameter int PC_W     = 32,
    parameter int RADDR_W  = 3,
    parameter int DATA_W   = 16,
    parameter int CNT_W    = 16
);
    logic                i_flush;
    logic                i_valid;
    logic                o_ready;
    logic [WB_SIZE-1:0]  i_WB;
    logic [MEM_SIZE-1:0] i_Mem;
    logic [EX_SIZE-1:0]  i_Ex;
    logic                i_chg_flag;
    logic [PC_W-1:0]     i_pc;
    logic [RADDR_W-1:0]  i_Rsrc1;
    logic [RADDR_W-1:0]  i_Rsrc2;
    logic [RADDR_W-1:0]  i_Rdst;
    logic [DATA_W-1:0]   i_immd;
    logic [DATA_W-1:0]   i_read_data1;
    logic [DATA_W-1:0]   i_read_data2;

    logic                o_valid;
    logic                i_ready;
    logic [WB_SIZE-1:0]  o_WB;
    logic [MEM_SIZE-1:0] o_Mem;
    logic [EX_SIZE-1:0]  o_Ex;
    logic                o_chg_flag;
    logic [PC_W-1:0]     o_pc;
    logic [RADDR_W-1:0]  o_Rsrc1;
    logic [RADDR_W-1:0]  o_Rsrc2;
    logic [RADDR_W-1:0]  o_Rdst;
    logic [DATA_W-1:0]   o_immd;
    logic [DATA_W-1:0]   o_read_data1;
    logic [DATA_W-1:0]   o_read_data2;
    logic [CNT_W-1:0]    o_stall_cnt;

    modport slave (
        input  i_flush, i_valid, i_WB, i_Mem, i_Ex, i_chg_flag, i_pc,
               i_Rsrc1, i_Rsrc2, i_Rdst, i_immd, i_read_data1, i_read_data2,
               i_ready,
        output o_ready, o_valid, o_WB, o_Mem, o_Ex, o_chg_flag, o_pc,
               o_Rsrc1, o_Rsrc2, o_Rdst, o_immd, o_read_data1, o_read_data2,
               o_stall_cnt
    );

    modport master (
        output i_flush, i_valid, i_WB, i_Mem, i_Ex, i_chg_flag, i_pc,
               i_Rsrc1, i_Rsrc2, i_Rdst, i_immd, i_read_data1, i_read_data2,
               i_ready,
        input  o_ready, o_valid, o_WB, o_Mem, o_Ex, o_chg_flag, o_pc,
               o_Rsrc1, o_Rsrc2, o_Rdst, o_immd, o_read_data1, o_read_data2,
               o_stall_cnt
    );
endinterface

`default_nettype wire

// File: rtl/id_ex_pipe_buf.sv
// ============================================================================
// Module      : id_ex_pipe_buf
// Description : ID/EX pipeline register with 2-entry skid buffer, flush,
//               bubble clearing of control fields and saturating stall counter.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module id_ex_pipe_buf #(
    parameter int WB_SIZE  = 4,
    parameter int MEM_SIZE = 6,
    parameter int EX_SIZE  = 3,
    parameter int PC_W     = 32,
    parameter int RADDR_W  = 3,
    parameter int DATA_W   = 16,
    parameter int CNT_W    = 16
) (
    input  wire logic          clk,
    input  wire logic          rst,
    id_ex_pipe_buf_if.slave    bus
);
    localparam int CTRL_W = WB_SIZE + MEM_SIZE + EX_SIZE + 1;
    localparam int DAT_W  = PC_W + 3 * RADDR_W + 3 * DATA_W;

    logic              main_valid_q, main_valid_d;
    logic [CTRL_W-1:0] main_ctrl_q,  main_ctrl_d;
    logic [DAT_W-1:0]  main_data_q,  main_data_d;
    logic              skid_valid_q, skid_valid_d;
    logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;
    logic [DAT_W-1:0]  skid_data_q,  skid_data_d;
    logic [CNT_W-1:0]  stall_cnt_q,  stall_cnt_d;

    logic              w_in_fire;
    logic              w_out_fire;
    logic [CTRL_W-1:0] w_in_ctrl;
    logic [DAT_W-1:0]  w_in_data;

    assign w_in_ctrl  = {bus.i_WB, bus.i_Mem, bus.i_Ex, bus.i_chg_flag};
    assign w_in_data  = {bus.i_pc, bus.i_Rsrc1, bus.i_Rsrc2, bus.i_Rdst,
                         bus.i_immd, bus.i_read_data1, bus.i_read_data2};

    // Ready depends only on skid occupancy, so there is no path from i_ready.
    assign bus.o_ready = ~skid_valid_q;
    assign w_in_fire   = bus.i_valid & ~skid_valid_q;
    assign w_out_fire  = main_valid_q & bus.i_ready;

    always_comb begin
        main_valid_d = main_valid_q;
        main_ctrl_d  = main_ctrl_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_ctrl_d  = skid_ctrl_q;
        skid_data_d  = skid_data_q;
        stall_cnt_d  = stall_cnt_q;

        if (bus.i_flush) begin
            main_valid_d = 1'b0;
            main_ctrl_d  = '0;
            skid_valid_d = 1'b0;
            skid_ctrl_d  = '0;
        end else begin
            if (main_valid_q && !bus.i_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
                stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end

            if (!main_valid_q || w_out_fire) begin
                if (skid_valid_q) begin
                    main_valid_d = 1'b1;
                    main_ctrl_d  = skid_ctrl_q;
                    main_data_d  = skid_data_q;
                    if (w_in_fire) begin
                        skid_ctrl_d = w_in_ctrl;
                        skid_data_d = w_in_data;
                    end else begin
                        skid_valid_d = 1'b0;
                        skid_ctrl_d  = '0;
                    end
                end else if (w_in_fire) begin
                    main_valid_d = 1'b1;
                    main_ctrl_d  = w_in_ctrl;
                    main_data_d  = w_in_data;
                end else begin
                    // Bubble: control cleared at the register, data left stale.
                    main_valid_d = 1'b0;
                    main_ctrl_d  = '0;
                end
            end else if (w_in_fire) begin
                skid_valid_d = 1'b1;
                skid_ctrl_d  = w_in_ctrl;
                skid_data_d  = w_in_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid_q <= 1'b0;
            main_ctrl_q  <= '0;
            main_data_q  <= '0;
            skid_valid_q <= 1'b0;
            skid_ctrl_q  <= '0;
            skid_data_q  <= '0;
            stall_cnt_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_ctrl_q  <= main_ctrl_d;
            main_data_q  <= main_data_d;
            skid_valid_q <= skid_valid_d;
            skid_ctrl_q  <= skid_ctrl_d;
            skid_data_q  <= skid_data_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign bus.o_valid = main_valid_q;
    assign {bus.o_WB, bus.o_Mem, bus.o_Ex, bus.o_chg_flag} = main_ctrl_q;
    assign {bus.o_pc, bus.o_Rsrc1, bus.o_Rsrc2, bus.o_Rdst,
            bus.o_immd, bus.o_read_data1, bus.o_read_data2} = main_data_q;
    assign bus.o_stall_cnt = stall_cnt_q;

endmodule

`default_nettype wire
